// File: rtl/adc_chan_deinterleave.sv
// ADC channel de-interleaver.
// Splits a time-multiplexed ADC sample bus carrying NUM_CHAN interleaved channels into one
// frame-aligned parallel word. Channel 0 of each frame is marked by sync_i.
//
// Ports:
//   clk_i        ADC sample clock
//   rst_n_i      asynchronous active-low reset
//   ce_i         sample valid; the bus is ignored when low
//   data_i       interleaved sample
//   sync_i       high with the channel-0 sample of a frame (qualified by ce_i)
//   clr_err_i    clears sync_err_o (a coincident new error wins)
//   data_o       last complete frame; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_o      one-cycle strobe, data_o holds a new frame
//   sync_err_o   sticky misplaced-sync flag
//   frame_cnt_o  completed frames since reset, wraps
module adc_chan_deinterleave #(
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned NUM_CHAN      = 2,
  parameter int unsigned OFFSET_BINARY = 0,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           ce_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic                           sync_i,
  input  logic                           clr_err_i,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] data_o,
  output logic                           valid_o,
  output logic                           sync_err_o,
  output logic [CNT_WIDTH-1:0]           frame_cnt_o
);

  localparam int unsigned IdxW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHAN - 1);

  typedef enum logic {StHunt, StLocked} state_e;

  state_e                                 state_q, state_d;
  logic [IdxW-1:0]                        idx_q, idx_d;
  logic [NUM_CHAN-1:0][DATA_WIDTH-1:0]    buf_q, buf_d;
  logic [NUM_CHAN*DATA_WIDTH-1:0]         data_q, data_d;
  logic                                   valid_q, valid_d;
  logic                                   err_q, err_d;
  logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] samp;
  logic [IdxW-1:0]       slot;
  logic                  store;
  logic                  err_set;

  always_comb begin
    samp = data_i;
    if (OFFSET_BINARY != 0) begin
      samp[DATA_WIDTH-1] = ~data_i[DATA_WIDTH-1];
    end

    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    slot    = idx_q;
    store   = 1'b0;
    err_set = 1'b0;

    if (ce_i) begin
      if (sync_i) begin
        // A sync always restarts the frame at channel 0; any partial frame is dropped.
        slot    = '0;
        store   = 1'b1;
        state_d = StLocked;
        if (state_q == StLocked && idx_q != '0) begin
          err_set = 1'b1;
        end
      end else if (state_q == StLocked) begin
        store = 1'b1;
      end
    end

    if (store) begin
      buf_d[slot] = samp;
      if (slot == LastIdx) begin
        data_d  = buf_d;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        idx_d   = '0;
      end else begin
        idx_d = slot + IdxW'(1);
      end
    end

    if (err_set) begin
      err_d = 1'b1;
    end else if (clr_err_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StHunt;
      idx_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign sync_err_o  = err_q;
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_adc_chan_deinterleave.sv
// Bench for adc_chan_deinterleave: three configurations driven by one shared stimulus stream,
// each checked every cycle against a frame-assembly model, plus directed literal checks.
module tb_adc_chan_deinterleave;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        sync = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] din = '0;

  // A: 2 channels, pass-through, 4-bit counter
  logic [23:0] a_data;
  logic        a_valid, a_err;
  logic [3:0]  a_cnt;
  // B: 4 channels, pass-through
  logic [47:0] b_data;
  logic        b_valid, b_err;
  logic [15:0] b_cnt;
  // C: 2 channels, offset-binary conversion
  logic [23:0] c_data;
  logic        c_valid, c_err;
  logic [15:0] c_cnt;

  always #5 clk_i = ~clk_i;

  adc_chan_deinterleave #(.DATA_WIDTH(12), .NUM_CHAN(2), .OFFSET_BINARY(0), .CNT_WIDTH(4)) u_a (
    .clk_i(clk_i), .rst_n_i(rst_n), .ce_i(ce), .data_i(din), .sync_i(sync), .clr_err_i(clr),
    .data_o(a_data), .valid_o(a_valid), .sync_err_o(a_err), .frame_cnt_o(a_cnt)
  );
  adc_chan_deinterleave #(.DATA_WIDTH(12), .NUM_CHAN(4), .OFFSET_BINARY(0), .CNT_WIDTH(16)) u_b (
    .clk_i(clk_i), .rst_n_i(rst_n), .ce_i(ce), .data_i(din), .sync_i(sync), .clr_err_i(clr),
    .data_o(b_data), .valid_o(b_valid), .sync_err_o(b_err), .frame_cnt_o(b_cnt)
  );
  adc_chan_deinterleave #(.DATA_WIDTH(12), .NUM_CHAN(2), .OFFSET_BINARY(1), .CNT_WIDTH(16)) u_c (
    .clk_i(clk_i), .rst_n_i(rst_n), .ce_i(ce), .data_i(din), .sync_i(sync), .clr_err_i(clr),
    .data_o(c_data), .valid_o(c_valid), .sync_err_o(c_err), .frame_cnt_o(c_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: samples collected for the frame being assembled, emitted once NUM_CHAN are held.
  int          nch [3] = '{2, 4, 2};
  int          obin[3] = '{0, 0, 1};
  int          cw  [3] = '{4, 16, 16};
  bit   [11:0] pend[3][4];
  int          npend[3];
  bit          locked[3];
  logic [47:0] exp_data[3];
  bit          exp_valid[3];
  bit          exp_err[3];
  int          exp_cnt[3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      npend[d] = 0; locked[d] = 0; exp_data[d] = '0;
      exp_valid[d] = 0; exp_err[d] = 0; exp_cnt[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      bit [11:0] s;
      bit        eset;
      eset = 0;
      s = din;
      if (obin[d] != 0) s[11] = ~s[11];
      exp_valid[d] = 0;
      if (ce) begin
        if (sync) begin
          if (locked[d] && npend[d] != 0) eset = 1;
          pend[d][0] = s; npend[d] = 1; locked[d] = 1;
        end else if (locked[d]) begin
          pend[d][npend[d]] = s; npend[d]++;
        end
        if (locked[d] && npend[d] == nch[d]) begin
          exp_data[d] = '0;
          for (int k = 0; k < nch[d]; k++) exp_data[d][k*12 +: 12] = pend[d][k];
          exp_valid[d] = 1;
          exp_cnt[d] = (exp_cnt[d] + 1) % (1 << cw[d]);
          npend[d] = 0;
        end
      end
      if (eset) exp_err[d] = 1;
      else if (clr) exp_err[d] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all three instances against the model.
  initial begin
    forever begin
      @(negedge clk_i);
      chk("A.data", 64'(a_data), 64'(exp_data[0]));
      chk("A.valid", 64'(a_valid), 64'(exp_valid[0]));
      chk("A.err", 64'(a_err), 64'(exp_err[0]));
      chk("A.cnt", 64'(a_cnt), 64'(exp_cnt[0]));
      chk("B.data", 64'(b_data), 64'(exp_data[1]));
      chk("B.valid", 64'(b_valid), 64'(exp_valid[1]));
      chk("B.err", 64'(b_err), 64'(exp_err[1]));
      chk("B.cnt", 64'(b_cnt), 64'(exp_cnt[1]));
      chk("C.data", 64'(c_data), 64'(exp_data[2]));
      chk("C.valid", 64'(c_valid), 64'(exp_valid[2]));
      chk("C.err", 64'(c_err), 64'(exp_err[2]));
      chk("C.cnt", 64'(c_cnt), 64'(exp_cnt[2]));
    end
  end

  // Drive one cycle of inputs just after a posedge, then step past the next posedge.
  task automatic cyc(input bit c, input bit s, input logic [11:0] d, input bit cl = 0);
    ce = c; sync = s; din = d; clr = cl;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    ce = 0; sync = 0; clr = 0; din = '0;
    rst_n = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1;
  endtask

  int nval;

  initial begin
    do_reset();
    chk("rst.a_data", 64'(a_data), 64'h0);
    chk("rst.a_cnt", 64'(a_cnt), 64'h0);
    chk("rst.b_err", 64'(b_err), 64'h0);

    // Two-channel basic framing
    cyc(1, 1, 12'h111);
    chk("t1.v0", 64'(a_valid), 64'h0);
    cyc(1, 0, 12'h222);
    chk("t1.v1", 64'(a_valid), 64'h1);
    chk("t1.d1", 64'(a_data), 64'h222111);
    cyc(1, 1, 12'h333);
    chk("t1.v2", 64'(a_valid), 64'h0);
    cyc(1, 0, 12'h444);
    chk("t1.v3", 64'(a_valid), 64'h1);
    chk("t1.d3", 64'(a_data), 64'h444333);
    chk("t1.cnt", 64'(a_cnt), 64'h2);
    chk("t1.err", 64'(a_err), 64'h0);

    // HUNT discards unsynced samples
    do_reset();
    nval = 0;
    cyc(1, 0, 12'h7FF); nval += a_valid;
    cyc(1, 0, 12'h7FE); nval += a_valid;
    cyc(1, 1, 12'h001); nval += a_valid;
    cyc(1, 0, 12'h002); nval += a_valid;
    chk("t2.nval", 64'(nval), 64'h1);
    chk("t2.d", 64'(a_data), 64'h002001);

    // ce gaps on four channels
    do_reset();
    cyc(1, 1, 12'h010);
    repeat (3) begin
      cyc(0, 1, 12'hFFF);
      chk("t3.gap_v", 64'(b_valid), 64'h0);
      chk("t3.gap_d", 64'(b_data), 64'h0);
    end
    cyc(1, 0, 12'h020);
    cyc(1, 0, 12'h030);
    chk("t3.v_early", 64'(b_valid), 64'h0);
    cyc(1, 0, 12'h040);
    chk("t3.v", 64'(b_valid), 64'h1);
    chk("t3.d", 64'(b_data), 64'h040030020010);
    cyc(0, 0, 12'h0);
    chk("t3.v_after", 64'(b_valid), 64'h0);

    // Misplaced sync on four channels
    do_reset();
    nval = 0;
    cyc(1, 1, 12'h001); nval += b_valid;
    cyc(1, 0, 12'h002); nval += b_valid;
    cyc(1, 1, 12'h0A0); nval += b_valid;
    chk("t4.err", 64'(b_err), 64'h1);
    cyc(1, 0, 12'h0B0); nval += b_valid;
    cyc(1, 0, 12'h0C0); nval += b_valid;
    cyc(1, 0, 12'h0D0); nval += b_valid;
    chk("t4.nval", 64'(nval), 64'h1);
    chk("t4.d", 64'(b_data), 64'h0D00C00B00A0);
    cyc(0, 0, 12'h0, 1);
    chk("t4.clr", 64'(b_err), 64'h0);
    cyc(1, 1, 12'h001);
    cyc(1, 1, 12'h002, 1);
    chk("t4.setwins", 64'(b_err), 64'h1);

    // Offset-binary conversion and asynchronous reset
    do_reset();
    cyc(1, 1, 12'h800);
    cyc(1, 0, 12'h000);
    chk("t5.v", 64'(c_valid), 64'h1);
    chk("t5.d", 64'(c_data), 64'h800000);
    cyc(1, 1, 12'h123);
    rst_n = 0;
    #1;
    chk("t5.rst_d", 64'(c_data), 64'h0);
    chk("t5.rst_cnt", 64'(c_cnt), 64'h0);
    @(posedge clk_i); #1 rst_n = 1;
    nval = 0;
    cyc(1, 0, 12'h456); nval += c_valid;
    cyc(1, 0, 12'h789); nval += c_valid;
    chk("t5.hunt", 64'(nval), 64'h0);
    cyc(1, 1, 12'h001);
    cyc(1, 0, 12'h002);
    chk("t5.d2", 64'(c_data), 64'h802801);

    // Counter wrap with back-to-back frames
    do_reset();
    nval = 0;
    for (int f = 0; f < 17; f++) begin
      cyc(1, 1, 12'(f));
      nval += a_valid;
      cyc(1, 0, 12'(f + 100));
      nval += a_valid;
    end
    chk("t6.nval", 64'(nval), 64'd17);
    chk("t6.cnt", 64'(a_cnt), 64'h1);

    // Randomised traffic, checked every cycle by the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
          12'($urandom_range(0, 4095)), $urandom_range(0, 19) == 0);
    end
    ce = 0; sync = 0; clr = 0;
    @(posedge clk_i); @(negedge clk_i); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
